// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: converts each qualified Gray sample to binary and flags non-+1 steps.
// Optional build macro GRAY_MON_HOLD_OK_EN: a repeated sample counts as a legal hold, not an error.
module gray_step_monitor #(
  parameter int N     = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     gray_in,
  input  logic             in_valid,
  output logic [N-1:0]     bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             wrap,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

`ifdef GRAY_MON_HOLD_OK_EN
  localparam bit HOLD_OK = 1'b1;
`else
  localparam bit HOLD_OK = 1'b0;
`endif

  state_t       state;
  logic [N-1:0] prev_bin;
  logic [N-1:0] new_bin;
  logic [N-1:0] expected;
  logic         acc;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    new_bin        = '0;
    acc            = gray_in[N-1];
    new_bin[N-1]   = acc;
    for (int i = N - 2; i >= 0; i--) begin
      acc        = acc ^ gray_in[i];
      new_bin[i] = acc;
    end
  end

  assign expected = prev_bin + N'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNLOCKED;
      prev_bin  <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      locked    <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      bin_valid <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      if (in_valid) begin
        bin_out   <= new_bin;
        prev_bin  <= new_bin;
        bin_valid <= 1'b1;
        case (state)
          UNLOCKED: begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
          LOCKED: begin
            if (new_bin == expected) begin
              wrap <= &prev_bin;
            end else if (HOLD_OK && (new_bin == prev_bin)) begin
              // Stalled upstream: accept the repeat silently.
            end else begin
              // Resync to the new value so a single glitch costs exactly one error.
              step_err <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Self-checking bench for gray_step_monitor: directed scenarios then random stimulus vs. a behavioural model.
// Two instances share the stimulus: default ERR_W and ERR_W=2 for counter saturation.
module tb_gray_step_monitor;

  localparam int N    = 4;
  localparam int MODN = 1 << N;

`ifdef GRAY_MON_HOLD_OK_EN
  localparam bit HOLD_OK = 1'b1;
`else
  localparam bit HOLD_OK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] gray_in;
  logic         in_valid;

  logic [N-1:0] bin_out,   bin_out_s;
  logic         bin_valid, bin_valid_s;
  logic         locked,    locked_s;
  logic         wrap,      wrap_s;
  logic         step_err,  step_err_s;
  logic [7:0]   err_count;
  logic [1:0]   err_count_s;

  gray_step_monitor #(.N(N), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .in_valid(in_valid),
    .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
    .wrap(wrap), .step_err(step_err), .err_count(err_count)
  );

  gray_step_monitor #(.N(N), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .gray_in(gray_in), .in_valid(in_valid),
    .bin_out(bin_out_s), .bin_valid(bin_valid_s), .locked(locked_s),
    .wrap(wrap_s), .step_err(step_err_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state, kept as plain integers.
  int  m_prev, m_bin, m_cnt8, m_cnt2;
  bit  m_locked, m_valid, m_wrap, m_err;
  int  cur_bin;
  int  err_pulses_s;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % MODN;
  endfunction

  // Each binary bit is the parity of the Gray bits at and above it.
  function automatic int from_gray(input int g);
    int b = 0;
    for (int i = 0; i < N; i++) b |= ((^(g >> i)) & 1) << i;
    return b;
  endfunction

  task automatic model_step(input bit r, input bit v, input int g);
    int nb;
    m_valid = 0; m_wrap = 0; m_err = 0;
    if (r) begin
      m_prev = 0; m_bin = 0; m_cnt8 = 0; m_cnt2 = 0; m_locked = 0;
    end else if (v) begin
      nb = from_gray(g);
      m_valid = 1;
      if (m_locked) begin
        if (nb == (m_prev + 1) % MODN)      m_wrap = (m_prev == MODN - 1);
        else if (!(HOLD_OK && nb == m_prev)) begin
          m_err  = 1;
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        end
      end
      m_locked = 1;
      m_prev   = nb;
      m_bin    = nb;
    end
  endtask

  // Apply one cycle of stimulus, then compare every output 1 time unit after the edge.
  task automatic drive(input bit r, input bit v, input int g);
    reset    = r;
    in_valid = v;
    gray_in  = g[N-1:0];
    @(posedge clk);
    #1;
    model_step(r, v, g);
    if (step_err_s) err_pulses_s++;
    check("bin_out",     int'(bin_out),     m_bin);
    check("bin_valid",   int'(bin_valid),   int'(m_valid));
    check("locked",      int'(locked),      int'(m_locked));
    check("wrap",        int'(wrap),        int'(m_wrap));
    check("step_err",    int'(step_err),    int'(m_err));
    check("err_count",   int'(err_count),   m_cnt8);
    check("err_count_s", int'(err_count_s), m_cnt2);
    check("step_err_s",  int'(step_err_s),  int'(m_err));
  endtask

  task automatic feed_bin(input int b);
    drive(0, 1, to_gray(b));
  endtask

  initial begin
    reset = 1; in_valid = 0; gray_in = '0;
    m_prev = 0; m_bin = 0; m_cnt8 = 0; m_cnt2 = 0; m_locked = 0;
    err_pulses_s = 0;
    drive(1, 0, 0);
    drive(1, 1, 5);

    // Full count through the wrap: 0..15, 0.
    for (int i = 0; i <= MODN; i++) feed_bin(i % MODN);
    check("wrap_end_bin", int'(bin_out), 0);
    check("no_err_seq", int'(err_count), 0);

    // Glitch 5 -> 8, then legal 8 -> 9.
    drive(1, 0, 0);
    for (int b = 3; b <= 5; b++) feed_bin(b);
    drive(0, 1, 4'b1100);
    check("glitch_err", int'(step_err), 1);
    drive(0, 1, 4'b1101);
    check("glitch_recover", int'(step_err), 0);

    // Repeated sample: legal only with the hold option.
    drive(0, 1, 4'b0011);
    drive(0, 1, 4'b0011);
    check("repeat_err", int'(step_err), HOLD_OK ? 0 : 1);

    // in_valid gap between legal samples.
    feed_bin(3);
    drive(0, 0, to_gray(9));
    drive(0, 0, to_gray(12));
    check("gap_hold", int'(bin_out), 3);
    feed_bin(4);

    // Mid-sequence reset with in_valid high, then re-lock on an arbitrary value.
    feed_bin(5);
    drive(1, 1, to_gray(6));
    check("rst_locked", int'(locked), 0);
    feed_bin(9);
    check("relock_no_err", int'(step_err), 0);

    // Saturate the narrow counter with 5 illegal steps.
    err_pulses_s = 0;
    for (int k = 0; k < 5; k++) feed_bin((cur_bin + 2 + k * 3) % MODN);
    check("sat_count", int'(err_count_s), 3);
    check("sat_pulses", err_pulses_s, 5);

    // Random traffic biased toward legal steps.
    cur_bin = m_prev;
    for (int n = 0; n < 2000; n++) begin
      int sel = $urandom_range(0, 99);
      int nb;
      if (sel < 2) begin
        drive(1, $urandom_range(0, 1), $urandom_range(0, MODN - 1));
        continue;
      end
      if (sel < 70)      nb = (m_prev + 1) % MODN;
      else if (sel < 80) nb = m_prev;
      else               nb = $urandom_range(0, MODN - 1);
      drive(0, (sel % 5) != 0, to_gray(nb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
